// File: rtl/sample_frame_buffer_if.sv
// Bus bundle for the ping-pong sample frame buffer: sample stream in,
// FFT handshake, and the bit-reversed read port used by the FFT load phase.
interface sample_frame_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);

  logic              sample_valid_i;
  logic [DATA_W-1:0] sample_data_i;
  logic              fft_done_i;
  logic [ADDR_W-1:0] read_address_i;
  logic [DATA_W-1:0] read_data_o;
  logic              start_o;
  logic              fft_busy_o;
  logic              write_bank_o;
  logic              overrun_o;
  logic              clear_overrun_i;
  logic [CNT_W-1:0]  dropped_cnt_o;

  // The master side is the sample source plus FFT engine.
  modport master (
    output sample_valid_i,
    output sample_data_i,
    output fft_done_i,
    output read_address_i,
    output clear_overrun_i,
    input  read_data_o,
    input  start_o,
    input  fft_busy_o,
    input  write_bank_o,
    input  overrun_o,
    input  dropped_cnt_o
  );

  modport slave (
    input  sample_valid_i,
    input  sample_data_i,
    input  fft_done_i,
    input  read_address_i,
    input  clear_overrun_i,
    output read_data_o,
    output start_o,
    output fft_busy_o,
    output write_bank_o,
    output overrun_o,
    output dropped_cnt_o
  );

endinterface

// File: rtl/sample_frame_buffer.sv
// Ping-pong capture buffer: fills one 2^ADDR_W-sample bank while the FFT reads
// the other, swapping banks and starting the FFT once a frame is complete.
module sample_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sample_frame_buffer_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] wr_ptr;
  logic              write_bank;
  logic              start;
  logic              fft_busy;
  logic              fft_done_q;
  logic              overrun;
  logic [CNT_W-1:0]  dropped_cnt;

  logic              swap_ok;
  logic              done_fall;
  logic              swap;
  logic              drop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank_sel;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_bank_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] read_data_q;

  assign swap_ok     = !fft_busy && !bus.fft_done_i;
  assign done_fall   = fft_done_q && !bus.fft_done_i;
  assign wr_bank_sel = write_bank ^ swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (bus.sample_valid_i && (wr_ptr == '1)) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (swap_ok) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // On the swap cycle a concurrent sample lands at address 0 of the new bank.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_ptr;
    swap    = 1'b0;
    drop    = 1'b0;
    case (state)
      FILL: begin
        wr_en = bus.sample_valid_i;
      end
      FULL: begin
        if (swap_ok) begin
          swap    = 1'b1;
          wr_en   = bus.sample_valid_i;
          wr_addr = '0;
        end else begin
          drop = bus.sample_valid_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      write_bank <= 1'b0;
      start      <= 1'b0;
      fft_busy   <= 1'b0;
      fft_done_q <= 1'b0;
    end else begin
      start      <= swap;
      fft_done_q <= bus.fft_done_i;
      if (wr_en) begin
        wr_ptr <= wr_addr + ADDR_W'(1);
      end
      if (swap) begin
        write_bank <= ~write_bank;
      end
      if (swap) begin
        fft_busy <= 1'b1;
      end else if (done_fall) begin
        fft_busy <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      dropped_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (bus.clear_overrun_i) begin
        dropped_cnt <= CNT_W'(1);
      end else if (dropped_cnt != '1) begin
        dropped_cnt <= dropped_cnt + CNT_W'(1);
      end
    end else if (bus.clear_overrun_i) begin
      overrun     <= 1'b0;
      dropped_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_sel, wr_addr}] <= bus.sample_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      rd_addr_q <= bus.read_address_i;
      rd_bank_q <= ~write_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q <= '0;
    end else begin
      ram_q <= mem[{rd_bank_q, rd_addr_q}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= ram_q;
    end
  end

  assign bus.read_data_o   = read_data_q;
  assign bus.start_o       = start;
  assign bus.fft_busy_o    = fft_busy;
  assign bus.write_bank_o  = write_bank;
  assign bus.overrun_o     = overrun;
  assign bus.dropped_cnt_o = dropped_cnt;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer: frame fill, bank swap timing,
// bit-reversed read sweep, overrun counting, clear priority and async reset.
module tb_sample_frame_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int N      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   start_pulses = 0;

  sample_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  sample_frame_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.start_o === 1'b1) start_pulses <= start_pulses + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [DATA_W-1:0] data);
    bus.sample_valid_i = valid;
    bus.sample_data_i  = data;
    tick();
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    bus.sample_valid_i = 1'b0;
    bus.read_address_i = addr;
    repeat (3) tick();
    check_output(tag, 32'(bus.read_data_o), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_start"}, 32'(bus.start_o), 32'd0);
    check_output({tag, "_busy"}, 32'(bus.fft_busy_o), 32'd0);
    check_output({tag, "_bank"}, 32'(bus.write_bank_o), 32'd0);
    check_output({tag, "_overrun"}, 32'(bus.overrun_o), 32'd0);
    check_output({tag, "_dropped"}, 32'(bus.dropped_cnt_o), 32'd0);
    check_output({tag, "_rdata"}, 32'(bus.read_data_o), 32'd0);
  endtask

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
    return r;
  endfunction

  initial begin
    int base;
    bus.sample_valid_i  = 1'b0;
    bus.sample_data_i   = '0;
    bus.fft_done_i      = 1'b0;
    bus.read_address_i  = '0;
    bus.clear_overrun_i = 1'b0;

    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Frame 0: sample value equals its index.
    base = start_pulses;
    for (int i = 0; i < N; i++) apply_stimulus(1'b1, DATA_W'(i));
    bus.sample_valid_i = 1'b0;
    check_output("f0_start_early", 32'(bus.start_o), 32'd0);
    tick();
    check_output("f0_start", 32'(bus.start_o), 32'd1);
    check_output("f0_bank", 32'(bus.write_bank_o), 32'd1);
    check_output("f0_busy", 32'(bus.fft_busy_o), 32'd1);
    tick();
    check_output("f0_start_once", 32'(bus.start_o), 32'd0);
    check_output("f0_pulses", 32'(start_pulses - base), 32'd1);

    // Bit-reversed sweep of bank 0 while frame 1 fills bank 1.
    for (int k = 0; k < N + 2; k++) begin
      bus.read_address_i = (k < N) ? bitrev(ADDR_W'(k)) : '0;
      bus.sample_valid_i = (k < N);
      bus.sample_data_i  = DATA_W'(32'h4000 + k);
      tick();
      if (k >= 2) check_output("sweep", 32'(bus.read_data_o), 32'(bitrev(ADDR_W'(k - 2))));
    end
    bus.sample_valid_i = 1'b0;
    check_output("f1_no_overrun", 32'(bus.overrun_o), 32'd0);
    check_output("f1_bank_hold", 32'(bus.write_bank_o), 32'd1);
    check_output("f1_pulses", 32'(start_pulses - base), 32'd1);

    repeat (5) apply_stimulus(1'b1, 16'hDEAD);
    bus.sample_valid_i = 1'b0;
    check_output("drop_overrun", 32'(bus.overrun_o), 32'd1);
    check_output("drop_cnt5", 32'(bus.dropped_cnt_o), 32'd5);
    check_output("drop_busy", 32'(bus.fft_busy_o), 32'd1);

    // FFT output phase: done held high blocks the swap.
    bus.fft_done_i = 1'b1;
    repeat (512) tick();
    check_output("done_hold_busy", 32'(bus.fft_busy_o), 32'd1);
    check_output("done_hold_bank", 32'(bus.write_bank_o), 32'd1);
    bus.fft_done_i = 1'b0;
    tick();
    check_output("fall_busy", 32'(bus.fft_busy_o), 32'd0);
    check_output("fall_start", 32'(bus.start_o), 32'd0);
    apply_stimulus(1'b1, 16'hABCD);
    bus.sample_valid_i = 1'b0;
    check_output("swap2_start", 32'(bus.start_o), 32'd1);
    check_output("swap2_bank", 32'(bus.write_bank_o), 32'd0);
    check_output("swap2_busy", 32'(bus.fft_busy_o), 32'd1);
    check_output("swap2_no_drop", 32'(bus.dropped_cnt_o), 32'd5);
    read_check("bank1_addr5", ADDR_W'(5), 16'h4005);

    // Release busy without a frame, then complete bank 0 from address 1.
    bus.fft_done_i = 1'b1;
    repeat (3) tick();
    bus.fft_done_i = 1'b0;
    repeat (2) tick();
    check_output("idle_busy", 32'(bus.fft_busy_o), 32'd0);
    base = start_pulses;
    for (int i = 1; i < N; i++) apply_stimulus(1'b1, DATA_W'(32'h2000 + i));
    bus.sample_valid_i = 1'b0;
    check_output("f2_start_early", 32'(bus.start_o), 32'd0);
    tick();
    check_output("f2_start", 32'(bus.start_o), 32'd1);
    check_output("f2_bank", 32'(bus.write_bank_o), 32'd1);
    read_check("bank0_addr0", ADDR_W'(0), 16'hABCD);
    read_check("bank0_addr1", ADDR_W'(1), 16'h2001);
    read_check("bank0_addr1023", ADDR_W'(N - 1), 16'h23FF);

    bus.clear_overrun_i = 1'b1;
    tick();
    bus.clear_overrun_i = 1'b0;
    check_output("clear_overrun", 32'(bus.overrun_o), 32'd0);
    check_output("clear_cnt", 32'(bus.dropped_cnt_o), 32'd0);

    // Fill bank 1 while busy, drop twice, then clear together with a drop.
    for (int i = 0; i < N; i++) apply_stimulus(1'b1, DATA_W'(32'h6000 + i));
    repeat (2) apply_stimulus(1'b1, 16'h1111);
    bus.sample_valid_i = 1'b0;
    check_output("drop_cnt2", 32'(bus.dropped_cnt_o), 32'd2);
    bus.clear_overrun_i = 1'b1;
    apply_stimulus(1'b1, 16'h2222);
    bus.clear_overrun_i = 1'b0;
    bus.sample_valid_i  = 1'b0;
    check_output("clr_drop_overrun", 32'(bus.overrun_o), 32'd1);
    check_output("clr_drop_cnt", 32'(bus.dropped_cnt_o), 32'd1);

    // Swap into bank 0, fill 600 samples, then reset asynchronously mid-cycle.
    bus.fft_done_i = 1'b1;
    repeat (2) tick();
    bus.fft_done_i = 1'b0;
    repeat (2) tick();
    check_output("f3_bank", 32'(bus.write_bank_o), 32'd0);
    bus.read_address_i = ADDR_W'(3);
    for (int i = 0; i < 600; i++) apply_stimulus(1'b1, DATA_W'(32'h7000 + i));
    bus.sample_valid_i = 1'b0;
    check_output("pre_rst_rdata", 32'(bus.read_data_o), 32'h6003);
    check_output("pre_rst_busy", 32'(bus.fft_busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    base = start_pulses;
    for (int i = 0; i < N - 1; i++) apply_stimulus(1'b1, DATA_W'(i));
    bus.sample_valid_i = 1'b0;
    repeat (2) tick();
    check_output("post_rst_no_start", 32'(start_pulses - base), 32'd0);
    apply_stimulus(1'b1, 16'h0055);
    bus.sample_valid_i = 1'b0;
    check_output("post_rst_start_early", 32'(bus.start_o), 32'd0);
    tick();
    check_output("post_rst_start", 32'(bus.start_o), 32'd1);
    check_output("post_rst_bank", 32'(bus.write_bank_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
